cfg_ro_loader: RTL and testbench

Holds the read-only configuration values (subsystem IDs, device serial number, per-AFU-function BAR0 size, PASID width and acTag length) that the config-space functions present to the host. Outputs start at parameter defaults. Values can be overwritten at bring-up from a word-stream load port driven by the flash/VPD reader. A checksum-verified commit applies new values atomically, and a lock prevents later changes. It sits between the VPD reader and the cfg_func0/cfg_func1..N instances; `cfg_ro_valid` gates their config responses.

---
 rtl/cfg_ro_loader.sv | 252 +++++++++++++++++++++++++
 tb/tb_cfg_ro_loader.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_ro_loader.sv
// cfg_ro_loader: read-only config values (subsystem IDs, DSN, per-function BAR0/PASID/acTag) with an optional VPD override path.
// The load/commit/lock machinery exists only when CFG_RO_OVERRIDE_EN is defined; otherwise outputs are constant defaults.
module cfg_ro_loader #(
    parameter int          NUM_AFU_FUNC    = 1,
    parameter int          TIMEOUT_CYCLES  = 1048576,
    parameter logic [15:0] DEF_SUBSYS_ID   = 16'h0666,
    parameter logic [15:0] DEF_SUBSYS_VID  = 16'h1014,
    parameter logic [63:0] DEF_DSN         = 64'hDEAD_DEAD_DEAD_DEAD,
    parameter logic [63:0] DEF_BAR0_SIZE   = 64'hFFFF_FFFF_FC00_0000,
    parameter logic [4:0]  DEF_PASID_WIDTH = 5'b01001,
    parameter logic [11:0] DEF_ACTAG_LEN   = 12'h020
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         ld_valid,
    output logic                         ld_ready,
    input  logic                         ld_commit,
    input  logic [4:0]                   ld_addr,
    input  logic [31:0]                  ld_data,
    output logic                         cfg_ro_valid,
    output logic                         ld_err_csum,
    output logic                         ld_err_locked,
    output logic [15:0]                  ro_subsystem_id,
    output logic [15:0]                  ro_subsystem_vendor_id,
    output logic [63:0]                  ro_dsn_serial_number,
    output logic [64*NUM_AFU_FUNC-1:0]   ro_bar0_size,
    output logic [5*NUM_AFU_FUNC-1:0]    ro_pasid_width,
    output logic [12*NUM_AFU_FUNC-1:0]   ro_actag_len
);

    localparam int NF = NUM_AFU_FUNC;
    localparam logic [64*NF-1:0] DEF_BAR0_ALL  = {NF{DEF_BAR0_SIZE}};
    localparam logic [5*NF-1:0]  DEF_PASID_ALL = {NF{DEF_PASID_WIDTH}};
    localparam logic [12*NF-1:0] DEF_ACTAG_ALL = {NF{DEF_ACTAG_LEN}};

`ifdef CFG_RO_OVERRIDE_EN

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_CHECK = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int            TW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TERM = TW'(TIMEOUT_CYCLES - 1);

    state_t           r_state;
    state_t           w_nextState;

    logic [15:0]      r_shSubsysId;
    logic [15:0]      r_shSubsysVid;
    logic [63:0]      r_shDsn;
    logic [64*NF-1:0] r_shBar0;
    logic [5*NF-1:0]  r_shPasid;
    logic [12*NF-1:0] r_shActag;

    logic [15:0]      r_lvSubsysId;
    logic [15:0]      r_lvSubsysVid;
    logic [63:0]      r_lvDsn;
    logic [64*NF-1:0] r_lvBar0;
    logic [5*NF-1:0]  r_lvPasid;
    logic [12*NF-1:0] r_lvActag;

    logic [31:0]      r_sum;
    logic [31:0]      r_expected;
    logic [TW-1:0]    r_timer;
    logic             r_errCsum;
    logic             r_errLocked;

    logic             w_acceptWrite;
    logic             w_acceptCommit;
    logic             w_checkPass;
    logic             w_checkFail;
    logic             w_lockedBeat;
    logic [2:0]       w_funcSel;
    logic             w_funcHit;

    // Per-function words live at 0x04+4k; the fourth word of each group is reserved.
    assign w_funcSel = ld_addr[4:2] - 3'd1;
    assign w_funcHit = (ld_addr[4:2] != 3'd0) && (ld_addr[1:0] != 2'd3) && (int'(w_funcSel) < NF);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState    = r_state;
        w_acceptWrite  = 1'b0;
        w_acceptCommit = 1'b0;
        w_checkPass    = 1'b0;
        w_checkFail    = 1'b0;
        w_lockedBeat   = 1'b0;
        unique case (r_state)
            ST_LOAD: begin
                if (r_timer == TERM) begin
                    w_nextState = ST_DONE;
                end else if (ld_valid) begin
                    if (ld_commit) begin
                        w_acceptCommit = 1'b1;
                        w_nextState    = ST_CHECK;
                    end else begin
                        w_acceptWrite = 1'b1;
                    end
                end
            end
            ST_CHECK: begin
                if (r_sum == r_expected) begin
                    w_checkPass = 1'b1;
                    w_nextState = ST_DONE;
                end else begin
                    w_checkFail = 1'b1;
                    w_nextState = ST_LOAD;
                end
            end
            ST_DONE: begin
                w_lockedBeat = ld_valid;
            end
            default: begin
                w_nextState = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_shSubsysId  <= DEF_SUBSYS_ID;
            r_shSubsysVid <= DEF_SUBSYS_VID;
            r_shDsn       <= DEF_DSN;
            r_shBar0      <= DEF_BAR0_ALL;
            r_shPasid     <= DEF_PASID_ALL;
            r_shActag     <= DEF_ACTAG_ALL;
            r_lvSubsysId  <= DEF_SUBSYS_ID;
            r_lvSubsysVid <= DEF_SUBSYS_VID;
            r_lvDsn       <= DEF_DSN;
            r_lvBar0      <= DEF_BAR0_ALL;
            r_lvPasid     <= DEF_PASID_ALL;
            r_lvActag     <= DEF_ACTAG_ALL;
            r_sum         <= 32'd0;
            r_expected    <= 32'd0;
            r_timer       <= '0;
            r_errCsum     <= 1'b0;
            r_errLocked   <= 1'b0;
        end else begin
            // Saturating at the terminal count lets an expiry during CHECK take effect back in LOAD.
            if ((r_state != ST_DONE) && (r_timer != TERM)) begin
                r_timer <= r_timer + 1'b1;
            end
            if (w_acceptWrite) begin
                r_sum <= r_sum + ld_data;
                case (ld_addr)
                    5'h00: begin
                        r_shSubsysId  <= ld_data[15:0];
                        r_shSubsysVid <= ld_data[31:16];
                    end
                    5'h01: r_shDsn[31:0]  <= ld_data;
                    5'h02: r_shDsn[63:32] <= ld_data;
                    default: begin
                        if (w_funcHit) begin
                            for (int k = 0; k < NF; k++) begin
                                if (w_funcSel == 3'(k)) begin
                                    case (ld_addr[1:0])
                                        2'd0: r_shBar0[64*k +: 32]    <= ld_data;
                                        2'd1: r_shBar0[64*k+32 +: 32] <= ld_data;
                                        2'd2: begin
                                            r_shPasid[5*k +: 5]   <= ld_data[4:0];
                                            r_shActag[12*k +: 12] <= ld_data[27:16];
                                        end
                                        default: ;
                                    endcase
                                end
                            end
                        end
                    end
                endcase
            end
            if (w_acceptCommit) begin
                r_expected <= ld_data;
            end
            if (w_checkPass) begin
                r_lvSubsysId  <= r_shSubsysId;
                r_lvSubsysVid <= r_shSubsysVid;
                r_lvDsn       <= r_shDsn;
                r_lvBar0      <= r_shBar0;
                r_lvPasid     <= r_shPasid;
                r_lvActag     <= r_shActag;
            end
            // A failed commit restarts the load from a clean slate so a retry sees no stale words.
            if (w_checkFail) begin
                r_errCsum     <= 1'b1;
                r_sum         <= 32'd0;
                r_shSubsysId  <= DEF_SUBSYS_ID;
                r_shSubsysVid <= DEF_SUBSYS_VID;
                r_shDsn       <= DEF_DSN;
                r_shBar0      <= DEF_BAR0_ALL;
                r_shPasid     <= DEF_PASID_ALL;
                r_shActag     <= DEF_ACTAG_ALL;
            end
            if (w_lockedBeat) begin
                r_errLocked <= 1'b1;
            end
        end
    end

    assign ld_ready               = (r_state != ST_CHECK);
    assign cfg_ro_valid           = (r_state == ST_DONE);
    assign ld_err_csum            = r_errCsum;
    assign ld_err_locked          = r_errLocked;
    assign ro_subsystem_id        = r_lvSubsysId;
    assign ro_subsystem_vendor_id = r_lvSubsysVid;
    assign ro_dsn_serial_number   = r_lvDsn;
    assign ro_bar0_size           = r_lvBar0;
    assign ro_pasid_width         = r_lvPasid;
    assign ro_actag_len           = r_lvActag;

`else

    logic r_valid;
    logic r_errLocked;
    logic w_unused;

    // Without the override path every beat is a late write into already-final values.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid     <= 1'b0;
            r_errLocked <= 1'b0;
        end else begin
            r_valid <= 1'b1;
            if (ld_valid) begin
                r_errLocked <= 1'b1;
            end
        end
    end

    assign w_unused               = ^{ld_commit, ld_addr, ld_data};
    assign ld_ready               = 1'b1;
    assign cfg_ro_valid           = r_valid;
    assign ld_err_csum            = 1'b0;
    assign ld_err_locked          = r_errLocked;
    assign ro_subsystem_id        = DEF_SUBSYS_ID;
    assign ro_subsystem_vendor_id = DEF_SUBSYS_VID;
    assign ro_dsn_serial_number   = DEF_DSN;
    assign ro_bar0_size           = DEF_BAR0_ALL;
    assign ro_pasid_width         = DEF_PASID_ALL;
    assign ro_actag_len           = DEF_ACTAG_ALL;

`endif

endmodule

// File: tb/tb_cfg_ro_loader.sv
// Testbench for cfg_ro_loader: a two-function and a one-function instance share one load stream.
// Covers both builds; the override scenarios run only when CFG_RO_OVERRIDE_EN is defined.
module tb_cfg_ro_loader;

    localparam int          TOUT  = 64;
    localparam logic [63:0] D_BAR = 64'hFFFF_FFFF_FC00_0000;
    localparam logic [63:0] D_DSN = 64'hDEAD_DEAD_DEAD_DEAD;
    localparam logic [4:0]  D_PAS = 5'b01001;
    localparam logic [11:0] D_ACT = 12'h020;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ldValid = 1'b0;
    logic        ldCommit = 1'b0;
    logic [4:0]  ldAddr = 5'h00;
    logic [31:0] ldData = 32'h0;

    logic         ldReady2, cfgValid2, errCsum2, errLocked2;
    logic [15:0]  sid2, vid2;
    logic [63:0]  dsn2;
    logic [127:0] bar2;
    logic [9:0]   pasid2;
    logic [23:0]  actag2;

    logic         ldReady1, cfgValid1, errCsum1, errLocked1;
    logic [15:0]  sid1, vid1;
    logic [63:0]  dsn1;
    logic [63:0]  bar1;
    logic [4:0]   pasid1;
    logic [11:0]  actag1;

    int errorCount = 0;
    int checkCount = 0;

    typedef struct {
        string       name;
        logic        rst, valid, commit;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        eValid, eReady, eCsum, eLocked;
        int          prof;
    } vec_t;

    typedef struct {
        string        name;
        logic         valid, ready, csum, locked;
        logic [15:0]  sid, vid;
        logic [63:0]  dsn;
        logic [127:0] bar;
        logic [9:0]   pasid;
        logic [23:0]  actag;
        logic [15:0]  sid1;
        logic [63:0]  bar1;
    } exp_t;

    vec_t vecs[$];
    exp_t sbQ[$];

    always #5 clock = ~clock;

    cfg_ro_loader #(.NUM_AFU_FUNC(2), .TIMEOUT_CYCLES(TOUT)) dut2 (
        .clock(clock), .reset(reset), .ld_valid(ldValid), .ld_ready(ldReady2),
        .ld_commit(ldCommit), .ld_addr(ldAddr), .ld_data(ldData),
        .cfg_ro_valid(cfgValid2), .ld_err_csum(errCsum2), .ld_err_locked(errLocked2),
        .ro_subsystem_id(sid2), .ro_subsystem_vendor_id(vid2), .ro_dsn_serial_number(dsn2),
        .ro_bar0_size(bar2), .ro_pasid_width(pasid2), .ro_actag_len(actag2)
    );

    cfg_ro_loader #(.NUM_AFU_FUNC(1), .TIMEOUT_CYCLES(TOUT)) dut1 (
        .clock(clock), .reset(reset), .ld_valid(ldValid), .ld_ready(ldReady1),
        .ld_commit(ldCommit), .ld_addr(ldAddr), .ld_data(ldData),
        .cfg_ro_valid(cfgValid1), .ld_err_csum(errCsum1), .ld_err_locked(errLocked1),
        .ro_subsystem_id(sid1), .ro_subsystem_vendor_id(vid1), .ro_dsn_serial_number(dsn1),
        .ro_bar0_size(bar1), .ro_pasid_width(pasid1), .ro_actag_len(actag1)
    );

    // Profile 0 = defaults, 1 = the good-commit word set, 2 = the unmapped/reserved write scenario.
    function automatic exp_t mkExp(input string n, input logic v, input logic r, input logic c,
                                   input logic l, input int prof);
        exp_t e;
        e.name = n; e.valid = v; e.ready = r; e.csum = c; e.locked = l;
        e.sid = 16'h0666; e.vid = 16'h1014; e.dsn = D_DSN;
        e.bar = {D_BAR, D_BAR}; e.pasid = {D_PAS, D_PAS}; e.actag = {D_ACT, D_ACT};
        e.sid1 = 16'h0666; e.bar1 = D_BAR;
        if (prof == 1) begin
            e.sid = 16'h0777; e.sid1 = 16'h0777;
            e.bar[127:64] = 64'hFFFF_FFFF_FFF0_0000;
            e.pasid[9:5] = 5'd1;
            e.actag[23:12] = 12'h001;
        end
        if (prof == 2) begin
            e.bar[127:64] = 64'hFFFF_FFFF_0000_0005;
        end
        return e;
    endfunction

    function automatic void addVec(input string n, input logic rs, input logic va, input logic cm,
                                   input logic [4:0] ad, input logic [31:0] da, input logic ev,
                                   input logic er, input logic ec, input logic el, input int pf);
        vec_t v;
        v.name = n; v.rst = rs; v.valid = va; v.commit = cm; v.addr = ad; v.data = da;
        v.eValid = ev; v.eReady = er; v.eCsum = ec; v.eLocked = el; v.prof = pf;
        vecs.push_back(v);
    endfunction

    task automatic cmp(input string n, input logic [127:0] act, input logic [127:0] exp);
        checkCount++;
        if (act !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", n, act, exp);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sbQ.size() == 0) begin
            checkCount++;
            errorCount++;
            $display("[TB] FAIL scoreboard: got empty queue, expected a pending entry");
            return;
        end
        e = sbQ.pop_front();
        cmp({e.name, ".valid"},  128'(cfgValid2),  128'(e.valid));
        cmp({e.name, ".ready"},  128'(ldReady2),   128'(e.ready));
        cmp({e.name, ".csum"},   128'(errCsum2),   128'(e.csum));
        cmp({e.name, ".locked"}, 128'(errLocked2), 128'(e.locked));
        cmp({e.name, ".sid"},    128'(sid2),       128'(e.sid));
        cmp({e.name, ".vid"},    128'(vid2),       128'(e.vid));
        cmp({e.name, ".dsn"},    128'(dsn2),       128'(e.dsn));
        cmp({e.name, ".bar"},    bar2,             e.bar);
        cmp({e.name, ".pasid"},  128'(pasid2),     128'(e.pasid));
        cmp({e.name, ".actag"},  128'(actag2),     128'(e.actag));
        cmp({e.name, ".f1valid"},  128'(cfgValid1),  128'(e.valid));
        cmp({e.name, ".f1ready"},  128'(ldReady1),   128'(e.ready));
        cmp({e.name, ".f1csum"},   128'(errCsum1),   128'(e.csum));
        cmp({e.name, ".f1locked"}, 128'(errLocked1), 128'(e.locked));
        cmp({e.name, ".f1sid"},    128'(sid1),       128'(e.sid1));
        cmp({e.name, ".f1vid"},    128'(vid1),       128'(e.vid));
        cmp({e.name, ".f1dsn"},    128'(dsn1),       128'(e.dsn));
        cmp({e.name, ".f1bar"},    128'(bar1),       128'(e.bar1));
        cmp({e.name, ".f1pasid"},  128'(pasid1),     128'(D_PAS));
        cmp({e.name, ".f1actag"},  128'(actag1),     128'(D_ACT));
    endtask

    task automatic expectNow(input string n, input logic v, input logic r, input logic c,
                             input logic l, input int prof);
        sbQ.push_back(mkExp(n, v, r, c, l, prof));
        checkOutput();
    endtask

    // Leaves reset released at a falling edge, so the next rising edge is the first one after release.
    task automatic doReset();
        @(negedge clock);
        reset   = 1'b1;
        ldValid = 1'b0;
        ldCommit = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Drives one beat for one edge, then samples just after that edge.
    task automatic applyStimulus(input vec_t v);
        if (v.rst) doReset();
        else @(negedge clock);
        ldValid  = v.valid;
        ldCommit = v.commit;
        ldAddr   = v.addr;
        ldData   = v.data;
        sbQ.push_back(mkExp(v.name, v.eValid, v.eReady, v.eCsum, v.eLocked, v.prof));
        @(posedge clock);
        #1;
        ldValid  = 1'b0;
        ldCommit = 1'b0;
        checkOutput();
    endtask

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: got no completion by time limit, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
`ifdef CFG_RO_OVERRIDE_EN
        // Sum of the four good words is 0x1005_0777.
        addVec("rst_idle",     1, 0, 0, 5'h00, 32'h0,         0, 1, 0, 0, 0);
        addVec("w00",          0, 1, 0, 5'h00, 32'h1014_0777, 0, 1, 0, 0, 0);
        addVec("w08",          0, 1, 0, 5'h08, 32'hFFF0_0000, 0, 1, 0, 0, 0);
        addVec("w09",          0, 1, 0, 5'h09, 32'hFFFF_FFFF, 0, 1, 0, 0, 0);
        addVec("w0A",          0, 1, 0, 5'h0A, 32'h0001_0001, 0, 1, 0, 0, 0);
        addVec("bad_commit",   0, 1, 1, 5'h00, 32'h1005_0778, 0, 0, 0, 0, 0);
        addVec("bad_check",    0, 0, 0, 5'h00, 32'h0,         0, 1, 1, 0, 0);
        addVec("r_w00",        0, 1, 0, 5'h00, 32'h1014_0777, 0, 1, 1, 0, 0);
        addVec("r_w08",        0, 1, 0, 5'h08, 32'hFFF0_0000, 0, 1, 1, 0, 0);
        addVec("r_w09",        0, 1, 0, 5'h09, 32'hFFFF_FFFF, 0, 1, 1, 0, 0);
        addVec("r_w0A",        0, 1, 0, 5'h0A, 32'h0001_0001, 0, 1, 1, 0, 0);
        addVec("good_commit",  0, 1, 1, 5'h00, 32'h1005_0777, 0, 0, 1, 0, 0);
        addVec("good_check",   0, 0, 0, 5'h00, 32'h0,         1, 1, 1, 0, 1);
        addVec("lock_w00",     0, 1, 0, 5'h00, 32'h0,         1, 1, 1, 1, 1);
        addVec("lock_commit",  0, 1, 1, 5'h00, 32'h0,         1, 1, 1, 1, 1);
        addVec("rst_w08",      1, 1, 0, 5'h08, 32'h5,         0, 1, 0, 0, 0);
        addVec("w03_rsvd",     0, 1, 0, 5'h03, 32'h7,         0, 1, 0, 0, 0);
        addVec("w07_rsvd",     0, 1, 0, 5'h07, 32'h10,        0, 1, 0, 0, 0);
        addVec("unmap_commit", 0, 1, 1, 5'h00, 32'h1C,        0, 0, 0, 0, 0);
        addVec("unmap_check",  0, 0, 0, 5'h00, 32'h0,         1, 1, 0, 0, 2);
        addVec("rst_w00",      1, 1, 0, 5'h00, 32'h1234_5678, 0, 1, 0, 0, 0);
        addVec("w01",          0, 1, 0, 5'h01, 32'h1,         0, 1, 0, 0, 0);
        addVec("rst_mid",      1, 0, 0, 5'h00, 32'h0,         0, 1, 0, 0, 0);
        addVec("zero_commit",  0, 1, 1, 5'h00, 32'h0,         0, 0, 0, 0, 0);
        addVec("zero_check",   0, 0, 0, 5'h00, 32'h0,         1, 1, 0, 0, 0);
`else
        addVec("idle_valid",   0, 0, 0, 5'h00, 32'h0,         1, 1, 0, 0, 0);
        addVec("beat_locks",   0, 1, 0, 5'h00, 32'h0,         1, 1, 0, 1, 0);
        addVec("commit_locks", 0, 1, 1, 5'h00, 32'h0,         1, 1, 0, 1, 0);
        addVec("rst_clears",   1, 0, 0, 5'h00, 32'h0,         1, 1, 0, 0, 0);
        addVec("beat_again",   0, 1, 0, 5'h01, 32'h1,         1, 1, 0, 1, 0);
`endif

        doReset();
        expectNow("reset", 0, 1, 0, 0, 0);
`ifdef CFG_RO_OVERRIDE_EN
        // No beats: valid must still be low after edge TOUT-1 and high after edge TOUT.
        repeat (TOUT - 1) @(posedge clock);
        #1;
        expectNow("tmo_pre", 0, 1, 0, 0, 0);
        @(posedge clock);
        #1;
        expectNow("tmo_edge", 1, 1, 0, 0, 0);
`else
        @(posedge clock);
        #1;
        expectNow("first_edge", 1, 1, 0, 0, 0);
`endif

        foreach (vecs[i]) applyStimulus(vecs[i]);

`ifdef CFG_RO_OVERRIDE_EN
        // Bad commit accepted on edge TOUT-1: CHECK completes, then the timeout fires from LOAD.
        doReset();
        repeat (TOUT - 2) @(posedge clock);
        @(negedge clock);
        ldValid  = 1'b1;
        ldCommit = 1'b1;
        ldAddr   = 5'h00;
        ldData   = 32'h1;
        @(posedge clock);
        #1;
        ldValid  = 1'b0;
        ldCommit = 1'b0;
        expectNow("tmo_chk_accept", 0, 0, 0, 0, 0);
        @(posedge clock);
        #1;
        expectNow("tmo_chk_fail", 0, 1, 1, 0, 0);
        @(posedge clock);
        #1;
        expectNow("tmo_chk_done", 1, 1, 1, 0, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
